// File: rtl/adder_rr_scheduler.sv
// adder_rr_scheduler: round-robin arbiter sharing one 32-bit carry-lookahead adder among NUM_REQ requesters
// Ports: i_clk/i_rst (async active-high); i_req_valid/o_req_ready + i_req_a/i_req_b (32 bits per requester);
//        o_rsp_valid/i_rsp_ready + o_rsp_sum/o_rsp_id/o_rsp_ovf response channel; o_busy high outside IDLE.
module carry_lookahead_adder (
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);
    logic [31:0] g, p, c;
    logic        carry;
    assign g = a & b;
    assign p = a ^ b;
    // 4-bit lookahead groups; the group carry hops between groups, final carry-out is dropped
    always_comb begin
        c = '0;
        carry = 1'b0;
        for (int j = 0; j < 8; j++) begin
            c[4*j]   = carry;
            c[4*j+1] = g[4*j] | (p[4*j] & carry);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & carry);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | (p[4*j+2] & p[4*j+1] & p[4*j] & carry);
            carry    = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                     | (p[4*j+3] & p[4*j+2] & p[4*j+1] & g[4*j]) | ((&p[4*j +: 4]) & carry);
        end
    end
    assign sum = p ^ c;
endmodule

module adder_rr_scheduler #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [NUM_REQ-1:0]      i_req_valid,
    output logic [NUM_REQ-1:0]      o_req_ready,
    input  logic [NUM_REQ*32-1:0]   i_req_a,
    input  logic [NUM_REQ*32-1:0]   i_req_b,
    output logic                    o_rsp_valid,
    input  logic                    i_rsp_ready,
    output logic [31:0]             o_rsp_sum,
    output logic [ID_W-1:0]         o_rsp_id,
    output logic                    o_rsp_ovf,
    output logic                    o_busy
);
    typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
    state_t            state, state_nxt;
    logic [ID_W-1:0]   rr_ptr, grant_id, ptr_nxt, op_id;
    logic [NUM_REQ-1:0] grant;
    logic              found, accept;
    logic [31:0]       sel_a, sel_b, op_a, op_b, sum;
    // two passes: indices at/above rr_ptr first, then the wrapped-around lower indices
    always_comb begin
        grant = '0;
        grant_id = '0;
        found = 1'b0;
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && i_req_valid[k] && k >= int'(rr_ptr)) begin
                found = 1'b1;
                grant[k] = 1'b1;
                grant_id = ID_W'(k);
                sel_a = i_req_a[32*k +: 32];
                sel_b = i_req_b[32*k +: 32];
            end
        end
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && i_req_valid[k]) begin
                found = 1'b1;
                grant[k] = 1'b1;
                grant_id = ID_W'(k);
                sel_a = i_req_a[32*k +: 32];
                sel_b = i_req_b[32*k +: 32];
            end
        end
    end
    assign o_req_ready = (state == IDLE && !i_rst) ? grant : '0;
    assign accept      = |o_req_ready;
    assign ptr_nxt     = (int'(grant_id) == NUM_REQ - 1) ? '0 : grant_id + 1'b1;
    assign state_nxt   = (state == IDLE) ? (accept ? CALC : IDLE) :
                         (state == CALC) ? RESP :
                         (i_rsp_ready ? IDLE : RESP);
    carry_lookahead_adder u_cla (.a(op_a), .b(op_b), .sum(sum));
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            op_a        <= '0;
            op_b        <= '0;
            op_id       <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_sum   <= '0;
            o_rsp_id    <= '0;
            o_rsp_ovf   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            state       <= state_nxt;
            o_busy      <= state_nxt != IDLE;
            o_rsp_valid <= state_nxt == RESP;
            if (accept) begin
                op_a   <= sel_a;
                op_b   <= sel_b;
                op_id  <= grant_id;
                rr_ptr <= ptr_nxt;
            end
            if (state == CALC) begin
                o_rsp_sum <= sum;
                o_rsp_id  <= op_id;
                o_rsp_ovf <= (op_a[31] == op_b[31]) && (sum[31] != op_a[31]);
            end
        end
    end
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// tb_adder_rr_scheduler: directed self-checking bench for adder_rr_scheduler
module tb_adder_rr_scheduler;
    logic         clk, rst, rsp_valid, rsp_ready, rsp_ovf, busy;
    logic [3:0]   req_valid, req_ready;
    logic [127:0] req_a, req_b;
    logic [31:0]  rsp_sum;
    logic [1:0]   rsp_id;
    int           n_cmp, n_err;

    adder_rr_scheduler #(.NUM_REQ(4), .ID_W(2)) dut (
        .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(req_ready),
        .i_req_a(req_a), .i_req_b(req_b), .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
        .o_rsp_sum(rsp_sum), .o_rsp_id(rsp_id), .o_rsp_ovf(rsp_ovf), .o_busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic run_txn(input int k, input logic [31:0] a, input logic [31:0] b,
                           output logic [3:0] rdy, output logic v, output logic [31:0] s,
                           output logic [1:0] id, output logic ov);
        @(negedge clk);
        req_a[32*k +: 32] = a;
        req_b[32*k +: 32] = b;
        req_valid[k] = 1'b1;
        #1 rdy = req_ready;
        @(negedge clk);
        req_valid[k] = 1'b0;
        @(negedge clk);
        v = rsp_valid; s = rsp_sum; id = rsp_id; ov = rsp_ovf;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 4'b1111; rsp_ready = 1'b0; req_a = '0; req_b = '0;
        repeat (2) @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL reset_ready: got %b expected 0000", req_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_sum !== 32'h0) begin n_err++; $display("FAIL reset_sum: got %h expected 0", rsp_sum); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d expected 0", rsp_id); end
        n_cmp++; if (rsp_ovf !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %b expected 0", rsp_ovf); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b expected 0", busy); end
        @(negedge clk);
        req_valid = 4'b0000;
        rst = 1'b0;
    endtask

    task automatic test_single;
        @(negedge clk);
        req_a[95:64] = 32'h5; req_b[95:64] = 32'h3; req_valid = 4'b0100;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL single_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL single_calc_busy: got %b expected 1", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_calc_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL single_calc_ready: got %b expected 0000", req_ready); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_valid: got %b expected 1", rsp_valid); end
        n_cmp++; if (rsp_sum !== 32'h8) begin n_err++; $display("FAIL single_sum: got %h expected 00000008", rsp_sum); end
        n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL single_id: got %0d expected 2", rsp_id); end
        n_cmp++; if (rsp_ovf !== 1'b0) begin n_err++; $display("FAIL single_ovf: got %b expected 0", rsp_ovf); end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_done_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL single_done_busy: got %b expected 0", busy); end
    endtask

    task automatic test_arith;
        logic [31:0] va [6] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h1234_5678, 32'h0000_FFFF, 32'hFFFF_FFFE};
        logic [31:0] vb [6] = '{32'h0000_0001, 32'h0000_0001, 32'h8000_0000, 32'h9ABC_DEF0, 32'h0000_0001, 32'hFFFF_FFFE};
        logic [31:0] vs [6] = '{32'h0000_0000, 32'h8000_0000, 32'h0000_0000, 32'hACF1_3568, 32'h0001_0000, 32'hFFFF_FFFC};
        logic        vo [6] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        logic [3:0]  rdy, exp_r;
        logic        v, ov;
        logic [31:0] s;
        logic [1:0]  id;
        for (int i = 0; i < 6; i++) begin
            run_txn(i % 4, va[i], vb[i], rdy, v, s, id, ov);
            exp_r = 4'b0001 << (i % 4);
            n_cmp++; if (rdy !== exp_r) begin n_err++; $display("FAIL arith%0d_ready: got %b expected %b", i, rdy, exp_r); end
            n_cmp++; if (v !== 1'b1) begin n_err++; $display("FAIL arith%0d_valid: got %b expected 1", i, v); end
            n_cmp++; if (s !== vs[i]) begin n_err++; $display("FAIL arith%0d_sum: got %h expected %h", i, s, vs[i]); end
            n_cmp++; if (id !== 2'(i % 4)) begin n_err++; $display("FAIL arith%0d_id: got %0d expected %0d", i, id, i % 4); end
            n_cmp++; if (ov !== vo[i]) begin n_err++; $display("FAIL arith%0d_ovf: got %b expected %b", i, ov, vo[i]); end
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_r;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            req_a[32*k +: 32] = 32'(k);
            req_b[32*k +: 32] = 32'd100;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        for (int c = 0; c < 18; c++) begin
            #1;
            exp_r = (c % 3 == 0) ? 4'b0001 << ((c / 3) % 4) : 4'b0000;
            n_cmp++; if (req_ready !== exp_r) begin n_err++; $display("FAIL fair_c%0d_ready: got %b expected %b", c, req_ready, exp_r); end
            n_cmp++; if (rsp_valid !== (c % 3 == 2)) begin n_err++; $display("FAIL fair_c%0d_valid: got %b expected %b", c, rsp_valid, c % 3 == 2); end
            if (c % 3 == 2) begin
                n_cmp++; if (rsp_id !== 2'((c / 3) % 4)) begin n_err++; $display("FAIL fair_c%0d_id: got %0d expected %0d", c, rsp_id, (c / 3) % 4); end
                n_cmp++; if (rsp_sum !== 32'(100 + (c / 3) % 4)) begin n_err++; $display("FAIL fair_c%0d_sum: got %0d expected %0d", c, rsp_sum, 100 + (c / 3) % 4); end
            end
            @(negedge clk);
        end
        req_valid = 4'b1010;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL fair_skip_ready: got %b expected 1000", req_ready); end
        repeat (3) @(negedge clk);
        #1;
        n_cmp++; if (req_ready !== 4'b0010) begin n_err++; $display("FAIL fair_next_ready: got %b expected 0010", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        repeat (2) @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_backpressure;
        for (int k = 0; k < 4; k++) begin
            req_a[32*k +: 32] = 32'(k) << 12;
            req_b[32*k +: 32] = 32'd7;
        end
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0100) begin n_err++; $display("FAIL bp_ready: got %b expected 0100", req_ready); end
        @(negedge clk);
        req_a[31:0] = 32'hFFFF_FFFF;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_calc_busy: got %b expected 1", busy); end
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            req_a[127:96] = 32'(c);
            #1;
            n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_c%0d_valid: got %b expected 1", c, rsp_valid); end
            n_cmp++; if (rsp_sum !== 32'h0000_2007) begin n_err++; $display("FAIL bp_c%0d_sum: got %h expected 00002007", c, rsp_sum); end
            n_cmp++; if (rsp_id !== 2'd2) begin n_err++; $display("FAIL bp_c%0d_id: got %0d expected 2", c, rsp_id); end
            n_cmp++; if (req_ready !== 4'b0000) begin n_err++; $display("FAIL bp_c%0d_ready: got %b expected 0000", c, req_ready); end
            n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL bp_c%0d_busy: got %b expected 1", c, busy); end
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL bp_rel_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL bp_rel_busy: got %b expected 0", busy); end
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL bp_rel_ready: got %b expected 1000", req_ready); end
        req_valid = 4'b0000;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req_a[127:96] = 32'h1; req_b[127:96] = 32'h1; req_valid = 4'b1000;
        #1;
        n_cmp++; if (req_ready !== 4'b1000) begin n_err++; $display("FAIL rcalc_ready: got %b expected 1000", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        #1;
        n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rcalc_busy_pre: got %b expected 1", busy); end
        #1 rst = 1'b1;
        #1;
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rcalc_busy: got %b expected 0", busy); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rcalc_valid: got %b expected 0", rsp_valid); end
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rcalc_norsp: got %b expected 0", rsp_valid); end
        @(negedge clk);
        req_a[95:64] = 32'h10; req_b[95:64] = 32'h20; req_valid = 4'b0100;
        @(negedge clk);
        req_valid = 4'b0000;
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL rresp_valid_pre: got %b expected 1", rsp_valid); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rresp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_sum !== 32'h0) begin n_err++; $display("FAIL rresp_sum: got %h expected 0", rsp_sum); end
        n_cmp++; if (rsp_id !== 2'd0) begin n_err++; $display("FAIL rresp_id: got %0d expected 0", rsp_id); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL rresp_busy: got %b expected 0", busy); end
        @(negedge clk);
        rst = 1'b0;
        req_valid = 4'b1111;
        #1;
        n_cmp++; if (req_ready !== 4'b0001) begin n_err++; $display("FAIL rresp_restart_ready: got %b expected 0001", req_ready); end
        @(negedge clk);
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rresp_idle_valid: got %b expected 0", rsp_valid); end
        rsp_ready = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_arith();
        test_fairness();
        test_backpressure();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
